// File: rtl/piezo_pkg.sv
// rtl/piezo_pkg.sv - shared state encoding and default widths for the piezo alert sequencer
package piezo_pkg;

  localparam int DIV_W_DEF = 16;
  localparam int DUR_W_DEF = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/piezo_tone_gen.sv
// rtl/piezo_tone_gen.sv - half-period counter and toggle flop producing the square-wave tone
module piezo_tone_gen
  import piezo_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] half_cnt,
  output logic             tone_out
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_tone;
  logic [DIV_W-1:0] w_lim;

  // A zero half-period behaves like one: toggle every cycle.
  assign w_lim = (half_cnt == '0) ? '0 : half_cnt - DIV_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_tone <= 1'b0;
    end else if (start) begin
      r_cnt  <= '0;
      r_tone <= 1'b1;
    end else if (r_cnt == w_lim) begin
      r_cnt  <= '0;
      r_tone <= ~r_tone;
    end else begin
      r_cnt  <= r_cnt + DIV_W'(1);
    end
  end

  assign tone_out = r_tone;

endmodule

// File: rtl/piezo_alert_seq.sv
// rtl/piezo_alert_seq.sv - prioritised alert arbiter and burst/gap sequencer driving a differential piezo
module piezo_alert_seq
  import piezo_pkg::*;
#(
  parameter int NUM_ALERTS = 3,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int DUR_W      = DUR_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_ALERTS-1:0]       req,
  input  logic [NUM_ALERTS*DIV_W-1:0] tone_half,
  input  logic [NUM_ALERTS*DUR_W-1:0] on_len,
  input  logic [NUM_ALERTS*DUR_W-1:0] off_len,
  output logic                        piezo,
  output logic                        piezo_n,
  output logic [NUM_ALERTS-1:0]       active,
  output logic                        busy
);

  localparam logic [NUM_ALERTS-1:0] ONE = {{(NUM_ALERTS-1){1'b0}}, 1'b1};

  state_t                r_state;
  state_t                w_state_nxt;
  logic [NUM_ALERTS-1:0] w_elig;
  logic [NUM_ALERTS-1:0] w_win;
  logic [NUM_ALERTS-1:0] r_active;
  logic                  w_any;
  logic                  w_higher;
  logic                  w_cur_elig;
  logic                  w_expire;
  logic                  w_latch;
  logic                  w_clr_cnt;
  logic [DIV_W-1:0]      w_sel_half;
  logic [DUR_W-1:0]      w_sel_on;
  logic [DUR_W-1:0]      w_sel_off;
  logic [DIV_W-1:0]      r_half;
  logic [DUR_W-1:0]      r_on;
  logic [DUR_W-1:0]      r_off;
  logic [DUR_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  w_tone;
  logic                  w_tone_rst;

  always_comb begin
    w_elig     = '0;
    w_sel_half = '0;
    w_sel_on   = '0;
    w_sel_off  = '0;
    for (int i = 0; i < NUM_ALERTS; i++) begin
      w_elig[i] = req[i] && (on_len[i*DUR_W +: DUR_W] != '0);
    end
    // Isolate the lowest set bit: index 0 has the highest priority.
    w_win = w_elig & (~w_elig + ONE);
    for (int i = 0; i < NUM_ALERTS; i++) begin
      if (w_win[i]) begin
        w_sel_half = tone_half[i*DIV_W +: DIV_W];
        w_sel_on   = on_len[i*DUR_W +: DUR_W];
        w_sel_off  = off_len[i*DUR_W +: DUR_W];
      end
    end
  end

  assign w_any      = |w_elig;
  assign w_cur_elig = |(w_elig & r_active);
  // Bits below the active one-hot bit are exactly the higher-priority channels.
  assign w_higher   = |(w_elig & (r_active - ONE));
  assign w_expire   = (r_state == TONE) ? (r_cnt == r_on - DUR_W'(1))
                                        : (r_cnt == r_off - DUR_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_clr_cnt   = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            w_state_nxt = TONE;
            w_latch     = 1'b1;
          end
        end
        TONE: begin
          if (w_higher) begin
            w_state_nxt = TONE;
            w_latch     = 1'b1;
          end else if (w_expire) begin
            if (w_cur_elig) begin
              w_state_nxt = GAP;
              w_clr_cnt   = 1'b1;
            end else if (w_any) begin
              w_state_nxt = TONE;
              w_latch     = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        GAP: begin
          if (w_higher) begin
            w_state_nxt = TONE;
            w_latch     = 1'b1;
          end else if (w_expire) begin
            if (w_any) begin
              w_state_nxt = TONE;
              w_latch     = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_active <= '0;
      r_busy   <= 1'b0;
      r_half   <= '0;
      r_on     <= '0;
      r_off    <= '0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_latch) begin
        r_active <= w_win;
        r_half   <= (w_sel_half == '0) ? DIV_W'(1) : w_sel_half;
        r_on     <= w_sel_on;
        r_off    <= (w_sel_off == '0) ? DUR_W'(1) : w_sel_off;
      end else if (w_state_nxt == IDLE) begin
        r_active <= '0;
      end
      if (w_latch || w_clr_cnt || (w_state_nxt == IDLE)) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + DUR_W'(1);
      end
    end
  end

  // Holding the tone generator in reset outside TONE keeps both legs low in IDLE and GAP.
  assign w_tone_rst = rst || (w_state_nxt != TONE);

  piezo_tone_gen #(
    .DIV_W(DIV_W)
  ) u_tone (
    .clk      (clk),
    .rst      (w_tone_rst),
    .start    (w_latch),
    .half_cnt (r_half),
    .tone_out (w_tone)
  );

  assign piezo   = w_tone;
  assign piezo_n = (r_state == TONE) && !w_tone;
  assign active  = r_active;
  assign busy    = r_busy;

endmodule

// File: tb/tb_piezo_alert_seq.sv
// tb/tb_piezo_alert_seq.sv - directed and randomized checks of piezo_alert_seq against a cycle model
module tb_piezo_alert_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  req;
  logic [15:0] th   [3];
  logic [23:0] onl  [3];
  logic [23:0] offl [3];
  logic [47:0] tone_half;
  logic [71:0] on_len;
  logic [71:0] off_len;
  logic        piezo;
  logic        piezo_n;
  logic [2:0]  active;
  logic        busy;

  assign tone_half = {th[2], th[1], th[0]};
  assign on_len    = {onl[2], onl[1], onl[0]};
  assign off_len   = {offl[2], offl[1], offl[0]};

  piezo_alert_seq #(
    .NUM_ALERTS(3),
    .DIV_W(16),
    .DUR_W(24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .tone_half (tone_half),
    .on_len    (on_len),
    .off_len   (off_len),
    .piezo     (piezo),
    .piezo_n   (piezo_n),
    .active    (active),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 silent, 1 sounding, 2 gap; m_el counts cycles elapsed in the current phase.
  int m_mode = 0;
  int m_cur  = 0;
  int m_el   = 0;
  int m_half = 1;
  int m_on   = 1;
  int m_off  = 1;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic m_start(input int w);
    m_mode = 1;
    m_cur  = w;
    m_el   = 0;
    m_half = (th[w] == 0) ? 1 : int'(th[w]);
    m_on   = int'(onl[w]);
    m_off  = (offl[w] == 0) ? 1 : int'(offl[w]);
  endtask

  task automatic m_edge();
    int  win;
    bit  cur_ok;
    win = -1;
    for (int i = 0; i < 3; i++) begin
      if (req[i] && onl[i] != 0 && win < 0) win = i;
    end
    cur_ok = req[m_cur] && (onl[m_cur] != 0);
    if (rst || !en) begin
      m_mode = 0;
      m_el   = 0;
    end else if (m_mode == 0) begin
      if (win >= 0) m_start(win);
    end else if (win >= 0 && win < m_cur) begin
      m_start(win);
    end else if (m_mode == 1) begin
      if (m_el + 1 == m_on) begin
        if (cur_ok) begin
          m_mode = 2;
          m_el   = 0;
        end else if (win >= 0) m_start(win);
        else m_mode = 0;
      end else m_el++;
    end else begin
      if (m_el + 1 == m_off) begin
        if (win >= 0) m_start(win);
        else m_mode = 0;
      end else m_el++;
    end
  endtask

  task automatic step();
    logic       e_p;
    logic [2:0] e_act;
    @(posedge clk);
    m_edge();
    #1;
    e_p   = (m_mode == 1) && (((m_el / m_half) % 2) == 0);
    e_act = (m_mode != 0) ? 3'(1 << m_cur) : 3'b000;
    expect_eq("m_piezo",   32'(piezo),   32'(e_p));
    expect_eq("m_piezo_n", 32'(piezo_n), 32'((m_mode == 1) && !e_p));
    expect_eq("m_active",  32'(active),  32'(e_act));
    expect_eq("m_busy",    32'(busy),    32'(m_mode != 0));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      step();
      n++;
    end
    expect_eq("idle_wait", 32'(busy), 32'd0);
  endtask

  int pat1 [13] = '{1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1};
  int pat2 [15] = '{0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      th[i]   = 16'd2;
      onl[i]  = 24'd8;
      offl[i] = 24'd4;
    end

    for (int k = 0; k < 5; k++) begin
      step();
      expect_eq("rst_outs", {28'd0, piezo, piezo_n, busy, |active}, 32'd0);
    end
    rst = 1'b0;
    req = 3'b000;
    step();

    req = 3'b100;
    for (int k = 0; k < 13; k++) begin
      step();
      expect_eq("single_piezo", 32'(piezo), 32'(pat1[k]));
      if (k < 8) expect_eq("single_active", 32'(active), 32'd4);
      if (k >= 8 && k < 12) expect_eq("single_gap_n", 32'(piezo_n), 32'd0);
    end

    th[0]   = 16'd1;
    onl[0]  = 24'd6;
    offl[0] = 24'd2;
    req     = 3'b101;
    step();
    expect_eq("preempt_active", 32'(active), 32'd1);
    expect_eq("preempt_piezo",  32'(piezo),  32'd1);
    step();
    expect_eq("preempt_tog0", 32'(piezo), 32'd0);
    step();
    expect_eq("preempt_tog1", 32'(piezo), 32'd1);
    req = 3'b000;
    wait_idle();

    req = 3'b100;
    for (int k = 0; k < 3; k++) step();
    req = 3'b000;
    for (int k = 0; k < 5; k++) begin
      step();
      expect_eq("drop_busy", 32'(busy), 32'd1);
    end
    step();
    expect_eq("drop_idle", 32'(busy), 32'd0);

    req = 3'b100;
    step();
    step();
    en = 1'b0;
    step();
    expect_eq("en_off", {28'd0, piezo, piezo_n, busy, |active}, 32'd0);
    en     = 1'b1;
    onl[1] = 24'd0;
    req    = 3'b010;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_eq("masked_busy", 32'(busy), 32'd0);
    end
    req = 3'b000;
    step();

    offl[2] = 24'd0;
    req     = 3'b100;
    step();
    step();
    th[2] = 16'd5;
    for (int k = 0; k < 15; k++) begin
      step();
      expect_eq("latch_piezo", 32'(piezo), 32'(pat2[k]));
      if (k == 6) expect_eq("gap1_busy", 32'(busy), 32'd1);
    end
    step();
    th[2] = 16'd0;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_eq("half0_piezo", 32'(piezo), 32'(k % 2 == 0));
    end
    req = 3'b000;
    wait_idle();

    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) begin
        int ch;
        ch       = $urandom_range(0, 2);
        th[ch]   = 16'($urandom_range(0, 3));
        onl[ch]  = 24'($urandom_range(0, 10));
        offl[ch] = 24'($urandom_range(0, 4));
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piezo_alert_seq.md
Name: piezo_alert_seq

Overview:
Parametrised successor to the three-input piezo driver. It arbitrates NUM_ALERTS prioritised alert requests and drives a differential piezo with per-alert tone pitch, burst length and gap length. Configuration is supplied on ports, so one RTL serves the segway alerts (norm_mode/ovr_spd/batt_low) and any future ones. It sits between the alert sources (balance control, battery monitor) and the piezo pads.

Parameters:
NUM_ALERTS, 3, number of alert channels; index 0 has the highest priority.
DIV_W, 16, width of each tone half-period count.
DUR_W, 24, width of each burst-length and gap-length count.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  global enable; low forces silence
req  in  NUM_ALERTS  level alert requests
tone_half  in  NUM_ALERTS*DIV_W  per-alert half-period in clk cycles; slice i is [i*DIV_W +: DIV_W]
on_len  in  NUM_ALERTS*DUR_W  per-alert burst length in cycles
off_len  in  NUM_ALERTS*DUR_W  per-alert gap length in cycles
piezo  out  1  piezo drive, positive leg
piezo_n  out  1  piezo drive, negative leg
active  out  NUM_ALERTS  one-hot index of the alert being sounded; zero when silent
busy  out  1  high in TONE or GAP

Behaviour:
- All outputs are registered. Reset values: piezo=0, piezo_n=0, active=0, busy=0, state=IDLE, all counters=0.
- Eligible alert i: req[i]=1 and on_len[i]!=0. Channels with on_len=0 are masked. The winner is the lowest eligible index.
- States:
  - IDLE: outputs silent. If en and any eligible alert exists at cycle t, latch the winner's tone_half/on_len/off_len and go to TONE. At t+1: piezo=1, piezo_n=0, active=winner, busy=1.
  - TONE: a half-period counter toggles piezo every tone_half cycles, with piezo_n = ~piezo. tone_half=0 is treated as 1. A burst counter runs for exactly on_len cycles. When it expires:
    - if the current alert is still eligible, go to GAP;
    - otherwise re-arbitrate: go to TONE with the new winner if one exists, else IDLE.
  - GAP: piezo=piezo_n=0 (no DC across the piezo) and busy=1. Lasts off_len cycles; off_len=0 is treated as 1. At expiry, re-arbitrate as in IDLE: go to TONE with the winner, else IDLE.
- Preemption: in TONE or GAP, if an eligible alert of higher priority than the active one appears at cycle u, then at u+1 the block is in TONE with the new winner latched, counters cleared and piezo=1.
- A request dropping mid-burst does not clip the burst. The burst completes, then the GAP is skipped.
- Config is latched only at burst start. Changes to the inputs mid-burst or mid-gap take effect at the next latch.
- en=0 in any state: the next cycle is IDLE with all outputs at reset values. Counters clear.
- rst overrides everything, including en and req, on the next edge.
- Counter widths match the parameters; compares are equality against the latched value minus 1. No wrap-around is possible.

Decomposition:
- Package piezo_pkg: state enum {IDLE, TONE, GAP} and default widths DIV_W_DEF=16, DUR_W_DEF=24.
- Sub-module piezo_tone_gen: half-period counter and toggle flop, with ports clk, rst, start, half_cnt, tone_out.
- The top level holds the priority arbiter, the burst/gap counter, the config latch and the FSM.

Test Plan:
- Reset: rst=1 with req=3'b111 and en=1 for 5 cycles -> piezo=0, piezo_n=0, active=0, busy=0 throughout.
- Single alert: req=3'b100, tone_half[2]=2, on_len[2]=8, off_len[2]=4, req rising at cycle t:
  - piezo=1 at t+1..t+2, 0 at t+3..t+4, 1 at t+5..t+6, 0 at t+7..t+8;
  - both legs 0 at t+9..t+12;
  - piezo=1 again at t+13;
  - active=3'b100 and piezo_n=~piezo in TONE.
- Preemption: during the req[2] burst, raise req[0] (tone_half[0]=1) at cycle u -> active=3'b001 and piezo=1 at u+1, then piezo toggles every cycle.
- Drop mid-burst: deassert req[2] 3 cycles into an 8-cycle burst -> burst finishes all 8 cycles, then IDLE with busy=0 on the next cycle and no GAP.
- Enable and masking: en=0 mid-TONE -> next cycle all outputs 0 and IDLE. With on_len[1]=0 and req=3'b010 -> stays IDLE.
- Config latch and zero handling: change tone_half[2] from 2 to 5 mid-burst -> the current burst keeps period 4 and the next burst uses period 10. tone_half=0 toggles every cycle. off_len=0 gives a 1-cycle gap.
